// File: rtl/mont_mul_cios.sv
// Word-serial Montgomery modular multiplier, Y = A*B*R^-1 mod M with R = 2^N.
// Each outer iteration multiplies one W-bit word of A by all of B (MUL), then
// cancels the low W bits of the accumulator with a multiple of M and shifts
// (RED). A final conditional subtraction brings the result below M.
// Optional build macro: MONT_RANGE_CHECK_EN. When defined, the start request
// is also rejected if a >= m or b >= m.
module mont_mul_cios #(
    parameter int N = 256,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] m,
    input  logic [W-1:0] m_inv,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] y
);

    localparam int S  = N / W;
    localparam int TW = N + W + 2;
    localparam int IW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_RED,
        S_FINAL,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  t_q, t_d;
    logic [IW-1:0]  i_q, i_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d, m_q, m_d, y_q, y_d;
    logic [W-1:0]   minv_q, minv_d;
    logic           err_q, err_d;

    logic           reject;
    logic           last_word;
    logic           red_active;
    logic [W-1:0]   a_word;
    logic [W-1:0]   q;
    logic [N+W-1:0] prod_ab;
    logic [N+W-1:0] prod_qm;
    logic [TW-1:0]  mul_sum;
    logic [TW-1:0]  red_sum;
    logic [TW-1:0]  m_ext;

`ifdef MONT_RANGE_CHECK_EN
    assign reject = ~m[0] | (a >= m) | (b >= m);
`else
    assign reject = ~m[0];
`endif

    assign last_word  = (i_q == IW'(S - 1));
    assign red_active = (state_q == S_RED);

    // Arithmetic shared by the MUL, RED and FINAL steps.
    assign a_word  = a_q[i_q*W +: W];
    assign prod_ab = (N+W)'(a_word) * (N+W)'(b_q);
    assign q       = t_q[W-1:0] * minv_q;
    assign prod_qm = (N+W)'(q) * (N+W)'(m_q);
    assign mul_sum = t_q + TW'(prod_ab);
    assign red_sum = t_q + TW'(prod_qm);
    assign m_ext   = TW'(m_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = reject ? S_DONE : S_MUL;
            S_MUL:   state_d = S_RED;
            S_RED:   state_d = last_word ? S_FINAL : S_MUL;
            S_FINAL: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: operand capture, accumulate, reduce, final subtract.
    always_comb begin
        t_d    = t_q;
        i_d    = i_q;
        a_d    = a_q;
        b_d    = b_q;
        m_d    = m_q;
        minv_d = minv_q;
        y_d    = y_q;
        err_d  = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        a_d    = a;
                        b_d    = b;
                        m_d    = m;
                        minv_d = m_inv;
                        t_d    = '0;
                        i_d    = '0;
                    end
                end
            end
            S_MUL:   t_d = mul_sum;
            // Low W bits of red_sum are zero by construction of q; dropping them divides by 2^W.
            S_RED:   t_d = red_sum >> W;
            S_FINAL: begin
                y_d   = (t_q >= m_ext) ? N'(t_q - m_ext) : N'(t_q);
                err_d = 1'b0;
            end
            S_DONE:  err_d = 1'b0;
            default: ;
        endcase
        if (red_active && !last_word) i_d = i_q + 1'b1;
    end

    // Datapath registers; reset clears everything so an aborted run leaves y = 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q    <= '0;
            i_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            minv_q <= '0;
            y_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            t_q    <= t_d;
            i_q    <= i_d;
            a_q    <= a_d;
            b_q    <= b_d;
            m_q    <= m_d;
            minv_q <= minv_d;
            y_q    <= y_d;
            err_q  <= err_d;
        end
    end

    // Outputs decoded from the current state and result registers.
    always_comb begin
        busy = (state_q == S_MUL) || (state_q == S_RED) || (state_q == S_FINAL);
        done = (state_q == S_DONE);
        err  = err_q;
        y    = y_q;
    end

endmodule

// File: tb/tb_mont_mul_cios.sv
// Self-checking bench for mont_mul_cios at N=16, W=8 against an arithmetic
// Montgomery model (modular product followed by N halvings mod m).
module tb_mont_mul_cios;

    localparam int N   = 16;
    localparam int W   = 8;
    localparam int S   = N / W;
    localparam int LAT = 2 * S + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a = '0, b = '0, m = '0;
    logic [W-1:0] m_inv = '0;
    logic         busy, done, err;
    logic [N-1:0] y;

    int checks = 0;
    int errors = 0;
    bit minv_ok = 1'b1;

    always #5 clk = ~clk;

    mont_mul_cios #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .m(m), .m_inv(m_inv),
        .busy(busy), .done(done), .err(err), .y(y)
    );

    // Reduction must always clear the low word when m_inv is correct.
    always @(negedge clk) begin
        if (!rst && minv_ok && dut.red_active) begin
            checks++;
            if (dut.red_sum[W-1:0] !== '0) begin
                errors++;
                $display("FAIL red_low_zero got %h want 00", dut.red_sum[W-1:0]);
            end
        end
    end

    // a*b*2^-N mod mm, for a,b < mm and odd mm.
    function automatic logic [N-1:0] mont_ref(input logic [N-1:0] aa, bb, mm);
        longint unsigned x;
        x = (64'(aa) * 64'(bb)) % 64'(mm);
        for (int k = 0; k < N; k++) begin
            if (x[0]) x = x + 64'(mm);
            x = x >> 1;
        end
        return N'(x);
    endfunction

    // -mm^-1 mod 2^W by search.
    function automatic logic [W-1:0] calc_minv(input logic [N-1:0] mm);
        for (longint qq = 0; qq < (64'd1 << W); qq++)
            if (((64'(mm) * qq + 1) % (64'd1 << W)) == 0) return W'(qq);
        return '0;
    endfunction

    // Issue one start pulse, scramble inputs after acceptance, wait for done.
    task automatic run_op(input logic [N-1:0] ta, tb_v, tm, input logic [W-1:0] tq,
                          output int lat, output logic e, output logic [N-1:0] yy,
                          output int bc);
        @(negedge clk);
        a = ta; b = tb_v; m = tm; m_inv = tq; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom); b = N'($urandom); m = N'($urandom); m_inv = W'($urandom);
        lat = 1; bc = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        e = err; yy = y;
    endtask

    task automatic test_reset();
        #2;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (err !== 1'b0)  begin errors++; $display("FAIL reset_err got %b want 0", err); end
        if (y !== '0)      begin errors++; $display("FAIL reset_y got %h want 0000", y); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_plan_vectors();
        logic [N-1:0] va[4] = '{16'h000F, 16'h000F, 16'h0000, 16'h1234};
        logic [N-1:0] vb[4] = '{16'h0005, 16'hFFF0, 16'h1234, 16'h0000};
        logic [N-1:0] vy[4] = '{16'h0005, 16'hFFF0, 16'h0000, 16'h0000};
        int lat, bc;
        logic e;
        logic [N-1:0] yy;
        for (int k = 0; k < 4; k++) begin
            run_op(va[k], vb[k], 16'hFFF1, 8'hEF, lat, e, yy, bc);
            checks += 4;
            if (lat !== LAT)  begin errors++; $display("FAIL plan%0d_latency got %0d want %0d", k, lat, LAT); end
            if (e !== 1'b0)   begin errors++; $display("FAIL plan%0d_err got %b want 0", k, e); end
            if (yy !== vy[k]) begin errors++; $display("FAIL plan%0d_y got %h want %h", k, yy, vy[k]); end
            if (bc !== 2*S+1) begin errors++; $display("FAIL plan%0d_busy_cycles got %0d want %0d", k, bc, 2*S+1); end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL plan%0d_done_pulse got %b want 0", k, done); end
        end
    endtask

    task automatic test_reject_even();
        int lat, bc;
        logic e;
        logic [N-1:0] yy;
        run_op(16'h000F, 16'h0007, 16'hFFF1, 8'hEF, lat, e, yy, bc);
        checks++;
        if (yy !== 16'h0007) begin errors++; $display("FAIL pre_reject_y got %h want 0007", yy); end
        run_op(16'h000F, 16'h0005, 16'hFFF0, 8'hEF, lat, e, yy, bc);
        checks += 4;
        if (lat !== 1)       begin errors++; $display("FAIL reject_latency got %0d want 1", lat); end
        if (e !== 1'b1)      begin errors++; $display("FAIL reject_err got %b want 1", e); end
        if (yy !== 16'h0007) begin errors++; $display("FAIL reject_y_kept got %h want 0007", yy); end
        if (bc !== 0)        begin errors++; $display("FAIL reject_busy got %0d want 0", bc); end
        @(negedge clk);
        checks += 2;
        if (err !== 1'b0)  begin errors++; $display("FAIL reject_err_clear got %b want 0", err); end
        if (done !== 1'b0) begin errors++; $display("FAIL reject_done_pulse got %b want 0", done); end
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        int first_c = -1;
        logic [N-1:0] y_at = '0;
        @(negedge clk);
        a = 16'h000F; b = 16'h1234; m = 16'hFFF1; m_inv = 8'hEF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = 16'h00F0; b = 16'h4321;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 3; c < 18; c++) begin
            if (done) begin
                pulses++;
                if (first_c < 0) begin first_c = c; y_at = y; end
            end
            @(negedge clk);
        end
        checks += 3;
        if (pulses !== 1)      begin errors++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
        if (first_c !== LAT)   begin errors++; $display("FAIL ignore_latency got %0d want %0d", first_c, LAT); end
        if (y_at !== 16'h1234) begin errors++; $display("FAIL ignore_y got %h want 1234", y_at); end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        logic e;
        logic [N-1:0] yy;
        @(negedge clk);
        a = 16'h000F; b = 16'h0005; m = 16'hFFF1; m_inv = 8'hEF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        if (y !== '0)      begin errors++; $display("FAIL abort_y got %h want 0000", y); end
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h000F, 16'h0007, 16'hFFF1, 8'hEF, lat, e, yy, bc);
        checks += 2;
        if (lat !== LAT)     begin errors++; $display("FAIL post_abort_latency got %0d want %0d", lat, LAT); end
        if (yy !== 16'h0007) begin errors++; $display("FAIL post_abort_y got %h want 0007", yy); end
    endtask

    task automatic test_random();
        int lat, bc;
        logic e;
        logic [N-1:0] yy, ta, tbv, tm, exp_y;
        for (int k = 0; k < 25; k++) begin
            tm = N'($urandom) | 16'h0001;
            if (tm < 3) tm = 16'h0003;
            ta = N'($urandom % tm);
            tbv = N'($urandom % tm);
            exp_y = mont_ref(ta, tbv, tm);
            run_op(ta, tbv, tm, calc_minv(tm), lat, e, yy, bc);
            checks += 3;
            if (lat !== LAT) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", k, lat, LAT); end
            if (e !== 1'b0)  begin errors++; $display("FAIL rand%0d_err got %b want 0", k, e); end
            if (yy !== exp_y) begin
                errors++;
                $display("FAIL rand%0d_y a=%h b=%h m=%h got %h want %h", k, ta, tbv, tm, yy, exp_y);
            end
        end
    endtask

    task automatic test_zero_product();
        int lat, bc;
        logic e;
        logic [N-1:0] yy;
        run_op(16'h0101, 16'h000F, 16'h0F0F, calc_minv(16'h0F0F), lat, e, yy, bc);
        checks += 2;
        if (yy !== mont_ref(16'h0101, 16'h000F, 16'h0F0F)) begin
            errors++; $display("FAIL zero_prod_y got %h want 0000", yy);
        end
        if (lat !== LAT) begin errors++; $display("FAIL zero_prod_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] qa[3], qb[3];
        int done_c[3];
        int k = 0;
        for (int j = 0; j < 3; j++) begin
            qa[j] = N'($urandom % 32'hFFF1);
            qb[j] = N'($urandom % 32'hFFF1);
            done_c[j] = -1;
        end
        @(negedge clk);
        a = qa[0]; b = qb[0]; m = 16'hFFF1; m_inv = 8'hEF; start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done && k < 3) begin
                done_c[k] = c;
                checks++;
                if (y !== mont_ref(qa[k], qb[k], 16'hFFF1)) begin
                    errors++;
                    $display("FAIL b2b%0d_y got %h want %h", k, y, mont_ref(qa[k], qb[k], 16'hFFF1));
                end
                k++;
                if (k < 3) begin a = qa[k]; b = qb[k]; end
                else start = 1'b0;
            end
        end
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (done_c[j] !== (LAT - 1) + j * (2*S+3)) begin
                errors++;
                $display("FAIL b2b%0d_done_cycle got %0d want %0d", j, done_c[j], (LAT - 1) + j * (2*S+3));
            end
        end
    endtask

    task automatic test_bad_minv();
        int lat, bc;
        logic e;
        logic [N-1:0] yy;
        minv_ok = 1'b0;
        run_op(16'h000F, 16'h0005, 16'hFFF1, 8'h12, lat, e, yy, bc);
        minv_ok = 1'b1;
        checks += 2;
        if (lat !== LAT) begin errors++; $display("FAIL bad_minv_latency got %0d want %0d", lat, LAT); end
        if (e !== 1'b0)  begin errors++; $display("FAIL bad_minv_err got %b want 0", e); end
    endtask

    task automatic test_range();
        int lat, bc;
        logic e;
        logic [N-1:0] yy, y_prev;
        y_prev = y;
        run_op(16'hFFF1, 16'h0005, 16'hFFF1, 8'hEF, lat, e, yy, bc);
`ifdef MONT_RANGE_CHECK_EN
        checks += 3;
        if (lat !== 1)     begin errors++; $display("FAIL range_latency got %0d want 1", lat); end
        if (e !== 1'b1)    begin errors++; $display("FAIL range_err got %b want 1", e); end
        if (yy !== y_prev) begin errors++; $display("FAIL range_y_kept got %h want %h", yy, y_prev); end
`else
        checks += 2;
        if (lat !== LAT) begin errors++; $display("FAIL range_latency got %0d want %0d", lat, LAT); end
        if (e !== 1'b0)  begin errors++; $display("FAIL range_err got %b want 0", e); end
`endif
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_reject_even();
        test_ignore_start();
        test_reset_abort();
        test_random();
        test_zero_product();
        test_back_to_back();
        test_bad_minv();
        test_range();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
